// File: rtl/trace_fabric_demux_n.sv
// Avalon-ST channel demultiplexer: 2-entry skid buffer, per-port registered output stage,
// and a saturating counter for beats whose port select names a non-existent port.
module trace_fabric_demux_n #(
   parameter int unsigned NUM_OUTPUTS   = 2,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned CHANNEL_WIDTH = 3,
   localparam int unsigned SEL_W        = $clog2(NUM_OUTPUTS),
   localparam int unsigned OCH_W        = CHANNEL_WIDTH - SEL_W
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic [CHANNEL_WIDTH-1:0]          in_channel,
   input  logic                              in_startofpacket,
   input  logic                              in_endofpacket,
   output logic [NUM_OUTPUTS-1:0]            out_valid,
   input  logic [NUM_OUTPUTS-1:0]            out_ready,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUTPUTS*OCH_W-1:0]      out_channel,
   output logic [NUM_OUTPUTS-1:0]            out_startofpacket,
   output logic [NUM_OUTPUTS-1:0]            out_endofpacket,
   output logic [15:0]                       drop_count,
   input  logic                              drop_clear
);

   localparam int unsigned BEAT_W   = DATA_WIDTH + CHANNEL_WIDTH + 2;
   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   logic [BEAT_W-1:0]               r_main, r_skid, w_main_nx, w_skid_nx, w_in_beat;
   logic                            r_main_valid, r_skid_valid, r_in_ready;
   logic                            w_main_valid_nx, w_skid_valid_nx;
   logic                            w_accept, w_consume, w_drop, w_port_rdy;
   logic [SEL_W-1:0]                w_sel;
   logic [DATA_WIDTH-1:0]           w_main_data;
   logic [OCH_W-1:0]                w_main_och;
   logic                            w_main_sop, w_main_eop;
   logic [NUM_OUTPUTS-1:0]          r_out_valid, r_out_sop, r_out_eop;
   logic [NUM_OUTPUTS*DATA_WIDTH-1:0] r_out_data;
   logic [NUM_OUTPUTS*OCH_W-1:0]    r_out_channel;
   logic [15:0]                     r_drop_count;

   // Beat layout: {sop, eop, channel, data}
   assign w_in_beat   = {in_startofpacket, in_endofpacket, in_channel, in_data};
   assign w_accept    = in_valid && r_in_ready;
   assign w_main_data = r_main[DATA_WIDTH-1:0];
   assign w_main_och  = r_main[DATA_WIDTH +: OCH_W];
   assign w_sel       = r_main[DATA_WIDTH+CHANNEL_WIDTH-1 -: SEL_W];
   assign w_main_eop  = r_main[BEAT_W-2];
   assign w_main_sop  = r_main[BEAT_W-1];
   assign w_drop      = 32'(w_sel) >= NUM_OUTPUTS;

   // Output stage of the selected port can take a beat this cycle
   always_comb begin
      w_port_rdy = 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (w_sel == SEL_W'(i)) w_port_rdy = out_ready[i] || !r_out_valid[i];
      end
   end

   assign w_consume = r_main_valid && (w_drop || w_port_rdy);

   // Skid buffer next state: refill main from skid first, then from the input
   always_comb begin
      w_main_nx       = r_main;
      w_main_valid_nx = r_main_valid;
      w_skid_nx       = r_skid;
      w_skid_valid_nx = r_skid_valid;
      if (!r_main_valid || w_consume) begin
         if (r_skid_valid) begin
            w_main_nx       = r_skid;
            w_main_valid_nx = 1'b1;
            w_skid_valid_nx = 1'b0;
         end else if (w_accept) begin
            w_main_nx       = w_in_beat;
            w_main_valid_nx = 1'b1;
         end else begin
            w_main_valid_nx = 1'b0;
         end
      end else if (w_accept) begin
         w_skid_nx       = w_in_beat;
         w_skid_valid_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b0;
      end else begin
         r_main       <= w_main_nx;
         r_skid       <= w_skid_nx;
         r_main_valid <= w_main_valid_nx;
         r_skid_valid <= w_skid_valid_nx;
         r_in_ready   <= !w_skid_valid_nx;
      end
   end

   // Per-port output registers; a new load wins over a drain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid   <= '0;
         r_out_sop     <= '0;
         r_out_eop     <= '0;
         r_out_data    <= '0;
         r_out_channel <= '0;
      end else begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (w_consume && !w_drop && (w_sel == SEL_W'(i))) begin
               r_out_valid[i]                         <= 1'b1;
               r_out_sop[i]                           <= w_main_sop;
               r_out_eop[i]                           <= w_main_eop;
               r_out_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_main_data;
               r_out_channel[i*OCH_W +: OCH_W]        <= w_main_och;
            end else if (out_ready[i]) begin
               r_out_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop_count <= '0;
      end else if (drop_clear) begin
         r_drop_count <= (w_consume && w_drop) ? 16'd1 : 16'd0;
      end else if (w_consume && w_drop && (r_drop_count != DROP_MAX)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign in_ready          = r_in_ready;
   assign out_valid         = r_out_valid;
   assign out_data          = r_out_data;
   assign out_channel       = r_out_channel;
   assign out_startofpacket = r_out_sop;
   assign out_endofpacket   = r_out_eop;
   assign drop_count        = r_drop_count;

endmodule

// File: tb/tb_trace_fabric_demux_n.sv
// Bench for trace_fabric_demux_n: a 2-port instance (power-of-2) and a 3-port instance
// (drops), both compared against per-port expected queues built from the routing rules.
`timescale 1ns/1ps
module tb_trace_fabric_demux_n;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Instance A: NUM_OUTPUTS=2, CHANNEL_WIDTH=3 (SEL_W=1, OCH_W=2)
   logic        a_in_valid, a_in_ready, a_sop, a_eop, a_drop_clear;
   logic [7:0]  a_in_data;
   logic [2:0]  a_in_ch;
   logic [1:0]  a_out_valid, a_out_ready, a_out_sop, a_out_eop;
   logic [15:0] a_out_data, a_drop_count;
   logic [3:0]  a_out_ch;

   // Instance B: NUM_OUTPUTS=3, CHANNEL_WIDTH=4 (SEL_W=2, OCH_W=2)
   logic        b_in_valid, b_in_ready, b_sop, b_eop, b_drop_clear;
   logic [7:0]  b_in_data;
   logic [3:0]  b_in_ch;
   logic [2:0]  b_out_valid, b_out_ready, b_out_sop, b_out_eop;
   logic [23:0] b_out_data;
   logic [5:0]  b_out_ch;
   logic [15:0] b_drop_count;

   trace_fabric_demux_n #(.NUM_OUTPUTS(2), .DATA_WIDTH(8), .CHANNEL_WIDTH(3)) u_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_channel(a_in_ch),
      .in_startofpacket(a_sop), .in_endofpacket(a_eop),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_channel(a_out_ch), .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop),
      .drop_count(a_drop_count), .drop_clear(a_drop_clear));

   trace_fabric_demux_n #(.NUM_OUTPUTS(3), .DATA_WIDTH(8), .CHANNEL_WIDTH(4)) u_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_channel(b_in_ch),
      .in_startofpacket(b_sop), .in_endofpacket(b_eop),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_channel(b_out_ch), .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
      .drop_count(b_drop_count), .drop_clear(b_drop_clear));

   // Beats are recorded as {sop, eop, out_channel[1:0], data[7:0]}
   logic [11:0] rx_a[2][$];
   logic [11:0] exp_a[2][$];
   logic [11:0] rx_b[3][$];
   logic [11:0] exp_b[3][$];
   int          rx_cyc_a[$];
   int          a_acc = 0;
   int          exp_drops = 0;
   logic [7:0]  bp_d[6];

   // Reference routing: upper channel bits pick the port, the rest travel with the beat
   function automatic void model_a(input logic [7:0] d, input logic [2:0] ch, input logic sop, input logic eop);
      exp_a[ch[2]].push_back({sop, eop, ch[1:0], d});
   endfunction

   function automatic void model_b(input logic [7:0] d, input logic [3:0] ch, input logic sop, input logic eop);
      int sel = int'(ch[3:2]);
      if (sel < 3) exp_b[sel].push_back({sop, eop, ch[1:0], d});
      else exp_drops++;
   endfunction

   // Collect every completed output handshake and every accepted input beat
   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (a_in_valid && a_in_ready) a_acc++;
         for (int i = 0; i < 2; i++) begin
            if (a_out_valid[i] && a_out_ready[i]) begin
               rx_a[i].push_back({a_out_sop[i], a_out_eop[i], a_out_ch[i*2 +: 2], a_out_data[i*8 +: 8]});
               rx_cyc_a.push_back(cyc);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (b_out_valid[i] && b_out_ready[i])
               rx_b[i].push_back({b_out_sop[i], b_out_eop[i], b_out_ch[i*2 +: 2], b_out_data[i*8 +: 8]});
         end
      end
   end

   task automatic clear_queues;
      for (int i = 0; i < 2; i++) begin rx_a[i].delete(); exp_a[i].delete(); end
      for (int i = 0; i < 3; i++) begin rx_b[i].delete(); exp_b[i].delete(); end
      rx_cyc_a.delete();
   endtask

   task automatic send_a(input logic [7:0] d, input logic [2:0] ch, input logic sop, input logic eop, output int waits);
      waits = 0;
      a_in_valid = 1'b1; a_in_data = d; a_in_ch = ch; a_sop = sop; a_eop = eop;
      @(negedge clk);
      while (!a_in_ready && waits < 200) begin @(negedge clk); waits++; end
      if (!a_in_ready) begin
         checks++; errors++;
         $display("FAIL send_a_timeout in_ready=%0b required=1", a_in_ready);
         @(posedge clk); #1; a_in_valid = 1'b0;
      end else begin
         @(posedge clk); #1; a_in_valid = 1'b0;
         model_a(d, ch, sop, eop);
      end
   endtask

   task automatic send_b(input logic [7:0] d, input logic [3:0] ch, input logic sop, input logic eop, output int waits);
      waits = 0;
      b_in_valid = 1'b1; b_in_data = d; b_in_ch = ch; b_sop = sop; b_eop = eop;
      @(negedge clk);
      while (!b_in_ready && waits < 200) begin @(negedge clk); waits++; end
      if (!b_in_ready) begin
         checks++; errors++;
         $display("FAIL send_b_timeout in_ready=%0b required=1", b_in_ready);
         @(posedge clk); #1; b_in_valid = 1'b0;
      end else begin
         @(posedge clk); #1; b_in_valid = 1'b0;
         model_b(d, ch, sop, eop);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      a_in_valid = 0; a_in_data = '0; a_in_ch = '0; a_sop = 0; a_eop = 0; a_drop_clear = 0; a_out_ready = '0;
      b_in_valid = 0; b_in_data = '0; b_in_ch = '0; b_sop = 0; b_eop = 0; b_drop_clear = 0; b_out_ready = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready got=%b%b want=00", a_in_ready, b_in_ready);
      end
      checks++;
      if (a_out_valid !== 2'b00 || b_out_valid !== 3'b000) begin
         errors++; $display("FAIL reset_out_valid got=%b/%b want=0", a_out_valid, b_out_valid);
      end
      checks++;
      if (a_out_data !== '0 || a_out_ch !== '0 || a_drop_count !== '0 || b_drop_count !== '0) begin
         errors++; $display("FAIL reset_payload data=%h ch=%h drops=%h/%h want=0", a_out_data, a_out_ch, a_drop_count, b_drop_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 1'b0) begin
         errors++; $display("FAIL release_in_ready_early got=%b want=0", a_in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         errors++; $display("FAIL release_in_ready got=%b%b want=11", a_in_ready, b_in_ready);
      end
   endtask

   task automatic test_single_beat;
      int w;
      clear_queues();
      a_out_ready = 2'b11;
      send_a(8'hA5, 3'b101, 1'b1, 1'b1, w);
      checks++;
      if (a_out_valid !== 2'b00) begin
         errors++; $display("FAIL single_t1_valid got=%b want=00", a_out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 2'b10) begin
         errors++; $display("FAIL single_t2_valid got=%b want=10", a_out_valid);
      end
      checks++;
      if (a_out_data[15:8] !== 8'hA5 || a_out_ch[3:2] !== 2'b01) begin
         errors++; $display("FAIL single_payload data=%h ch=%b want=a5/01", a_out_data[15:8], a_out_ch[3:2]);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (rx_a[0].size() != 0 || rx_a[1].size() != 1 || exp_a[1].size() != 1) begin
         errors++; $display("FAIL single_counts p0=%0d p1=%0d want=0/1", rx_a[0].size(), rx_a[1].size());
      end else if (rx_a[1][0] !== exp_a[1][0]) begin
         errors++; $display("FAIL single_beat got=%h want=%h", rx_a[1][0], exp_a[1][0]);
      end
   endtask

   task automatic test_streaming;
      int w, tw;
      logic [2:0] ch;
      tw = 0;
      clear_queues();
      a_out_ready = 2'b11;
      for (int i = 0; i < 64; i++) begin
         ch = {1'(i % 2), 2'($urandom)};
         send_a(8'($urandom), ch, 1'($urandom), 1'($urandom), w);
         tw += w;
      end
      repeat (4) @(posedge clk); #1;
      checks++;
      if (tw != 0) begin
         errors++; $display("FAIL stream_in_ready_stalls got=%0d want=0", tw);
      end
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (rx_a[p].size() != exp_a[p].size()) begin
            errors++; $display("FAIL stream_count p%0d got=%0d want=%0d", p, rx_a[p].size(), exp_a[p].size());
         end else begin
            for (int k = 0; k < rx_a[p].size(); k++) begin
               checks++;
               if (rx_a[p][k] !== exp_a[p][k]) begin
                  errors++; $display("FAIL stream_beat p%0d[%0d] got=%h want=%h", p, k, rx_a[p][k], exp_a[p][k]);
               end
            end
         end
      end
      checks++;
      if (rx_cyc_a.size() != 64) begin
         errors++; $display("FAIL stream_total got=%0d want=64", rx_cyc_a.size());
      end else if (rx_cyc_a[63] - rx_cyc_a[0] != 63) begin
         errors++; $display("FAIL stream_gaps span=%0d want=63", rx_cyc_a[63] - rx_cyc_a[0]);
      end
   endtask

   task automatic bp_sender;
      int w;
      for (int k = 0; k < 6; k++) send_a(bp_d[k], {1'b0, 2'(k)}, 1'(k == 0), 1'(k == 5), w);
   endtask

   task automatic test_backpressure;
      int acc0, n;
      clear_queues();
      a_out_ready = 2'b10;
      acc0 = a_acc;
      for (int k = 0; k < 6; k++) bp_d[k] = 8'($urandom);
      fork
         bp_sender();
      join_none
      repeat (10) @(posedge clk); #1;
      checks++;
      if (a_acc - acc0 != 3) begin
         errors++; $display("FAIL bp_accepts got=%0d want=3", a_acc - acc0);
      end
      checks++;
      if (a_in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_in_ready got=%b want=0", a_in_ready);
      end
      repeat (5) @(posedge clk); #1;
      checks++;
      if (a_out_valid[0] !== 1'b1 || a_out_data[7:0] !== bp_d[0] || a_out_sop[0] !== 1'b1) begin
         errors++; $display("FAIL bp_hold valid=%b data=%h sop=%b want=1/%h/1", a_out_valid[0], a_out_data[7:0], a_out_sop[0], bp_d[0]);
      end
      a_out_ready = 2'b11;
      n = 0;
      while (rx_a[0].size() < 6 && n < 100) begin @(posedge clk); n++; end
      repeat (4) @(posedge clk); #1;
      checks++;
      if (rx_a[0].size() != 6 || exp_a[0].size() != 6) begin
         errors++; $display("FAIL bp_count got=%0d want=6", rx_a[0].size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (rx_a[0][k] !== exp_a[0][k]) begin
               errors++; $display("FAIL bp_beat[%0d] got=%h want=%h", k, rx_a[0][k], exp_a[0][k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int w;
      clear_queues();
      a_out_ready = 2'b10;
      for (int k = 0; k < 3; k++) send_a(8'($urandom), 3'(k), 1'b0, 1'b0, w);
      #2;
      checks++;
      if (a_out_valid[0] !== 1'b1 || a_in_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_filled valid=%b in_ready=%b want=1/0", a_out_valid[0], a_in_ready);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 2'b00 || a_in_ready !== 1'b0 || a_out_data !== '0) begin
         errors++; $display("FAIL rstmid_async valid=%b in_ready=%b data=%h want=0", a_out_valid, a_in_ready, a_out_data);
      end
      clear_queues();
      a_out_ready = 2'b11;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      checks++;
      if (rx_a[0].size() != 0 || rx_a[1].size() != 0 || a_out_valid !== 2'b00 || a_in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_stale rx=%0d/%0d valid=%b in_ready=%b want=0/0/00/1",
                            rx_a[0].size(), rx_a[1].size(), a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_drops;
      int w;
      logic [3:0] ch;
      clear_queues();
      exp_drops = 0;
      b_out_ready = 3'b111;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) ch = {2'b11, 2'($urandom)};
         else ch = {2'(i % 3), 2'($urandom)};
         send_b(8'($urandom), ch, 1'($urandom), 1'($urandom), w);
      end
      repeat (6) @(posedge clk); #1;
      checks++;
      if (b_drop_count !== 16'(exp_drops)) begin
         errors++; $display("FAIL drop_count got=%0d want=%0d", b_drop_count, exp_drops);
      end
      checks++;
      if (b_out_valid !== 3'b000) begin
         errors++; $display("FAIL drop_idle_valid got=%b want=000", b_out_valid);
      end
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (rx_b[p].size() != exp_b[p].size()) begin
            errors++; $display("FAIL drop_port_count p%0d got=%0d want=%0d", p, rx_b[p].size(), exp_b[p].size());
         end else begin
            for (int k = 0; k < rx_b[p].size(); k++) begin
               checks++;
               if (rx_b[p][k] !== exp_b[p][k]) begin
                  errors++; $display("FAIL drop_beat p%0d[%0d] got=%h want=%h", p, k, rx_b[p][k], exp_b[p][k]);
               end
            end
         end
      end
      // Clear lands on the same edge that retires the dropped beat
      send_b(8'h3C, 4'b1100, 1'b0, 1'b0, w);
      b_drop_clear = 1'b1;
      @(posedge clk); #1;
      b_drop_clear = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (b_drop_count !== 16'd1) begin
         errors++; $display("FAIL drop_clear_coincident got=%0d want=1", b_drop_count);
      end
      b_drop_clear = 1'b1;
      @(posedge clk); #1;
      b_drop_clear = 1'b0;
      checks++;
      if (b_drop_count !== 16'd0) begin
         errors++; $display("FAIL drop_clear got=%0d want=0", b_drop_count);
      end
   endtask

   task automatic test_saturation;
      int w, sat;
      exp_drops = 0;
      for (int i = 0; i < 65540; i++) send_b(8'($urandom), {2'b11, 2'($urandom)}, 1'b0, 1'b0, w);
      repeat (4) @(posedge clk); #1;
      sat = (exp_drops > 65535) ? 65535 : exp_drops;
      checks++;
      if (b_drop_count !== 16'(sat)) begin
         errors++; $display("FAIL drop_saturation got=%h want=%h", b_drop_count, 16'(sat));
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_streaming();
      test_backpressure();
      test_reset_mid();
      test_drops();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
